// File: rtl/ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_seq_pkg
//  Brief    : Shared types and constants for the control sequencer: FSM state
//             encoding, opcode values, ALU operation codes, instruction class.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_seq_pkg;

  // Sequencer states, 3-bit encoded
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_t;

  // Opcode values found in IR[15:12]
  localparam logic [3:0] c_op_alu    = 4'b0000;
  localparam logic [3:0] c_op_load   = 4'b1001;
  localparam logic [3:0] c_op_store  = 4'b1010;
  localparam logic [3:0] c_op_branch = 4'b1100;
  localparam logic [3:0] c_op_halt   = 4'b1111;

  // ALU operation codes (ADD used for address generation, SUB for compare)
  localparam logic [3:0] c_alu_add = 4'b0000;
  localparam logic [3:0] c_alu_sub = 4'b0001;

  // Instruction class produced by the opcode decoder
  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

endpackage : ctrl_seq_pkg
`default_nettype wire

// File: rtl/ctrl_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_sequencer_if
//  Brief    : Memory handshake and datapath control bundle between the
//             sequencer (master) and the memory/datapath side (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface ctrl_sequencer_if;

  logic [15:0] instr_in;
  logic        mem_ack;
  logic        flag_z;
  logic        mem_rd;
  logic        mem_wr;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_load;
  logic        reg_we;
  logic [3:0]  alu_op;
  logic        arith_mux;
  logic        halted;
  logic        trap;

  modport master (
    input  instr_in, mem_ack, flag_z,
    output mem_rd, mem_wr, ir_load, pc_inc, pc_load, reg_we,
           alu_op, arith_mux, halted, trap
  );

  modport slave (
    output instr_in, mem_ack, flag_z,
    input  mem_rd, mem_wr, ir_load, pc_inc, pc_load, reg_we,
           alu_op, arith_mux, halted, trap
  );

endinterface : ctrl_sequencer_if
`default_nettype wire

// File: rtl/ctrl_opdec.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_opdec
//  Brief    : Combinational opcode decoder: instruction class, ALU operation
//             and B-operand select from the opcode and function field.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_opdec
  import ctrl_seq_pkg::*;
(
  input  wire logic [3:0] i_opcode,
  input  wire logic [3:0] i_func,
  output op_class_t       o_op_class,
  output logic [3:0]      o_alu_op,
  output logic            o_arith_mux
);

  // Map opcode to class; memory ops add an immediate offset, branches compare
  always_comb begin
    o_op_class  = CLS_ILLEGAL;
    o_alu_op    = c_alu_add;
    o_arith_mux = 1'b0;
    case (i_opcode)
      c_op_alu: begin
        o_op_class = CLS_ALU;
        o_alu_op   = i_func;
      end
      c_op_load: begin
        o_op_class  = CLS_LOAD;
        o_arith_mux = 1'b1;
      end
      c_op_store: begin
        o_op_class  = CLS_STORE;
        o_arith_mux = 1'b1;
      end
      c_op_branch: begin
        o_op_class = CLS_BRANCH;
        o_alu_op   = c_alu_sub;
      end
      c_op_halt: begin
        o_op_class = CLS_HALT;
      end
      default: begin
        o_op_class = CLS_ILLEGAL;
      end
    endcase
  end

endmodule : ctrl_opdec
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_sequencer
//  Brief    : Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB FSM
//             with instruction register and registered ALU controls.
//             Build option: CTRL_SEQ_ILLEGAL_TRAP_EN sends illegal opcodes to
//             a sticky TRAP state; otherwise they execute as a NOP.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_sequencer
  import ctrl_seq_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst,
  ctrl_sequencer_if.master  bus
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_ir;
  logic [3:0]  r_alu_op;
  logic        r_arith_mux;

  op_class_t   w_class;
  logic [3:0]  w_dec_alu_op;
  logic        w_dec_arith_mux;

  logic        w_mem_rd;
  logic        w_mem_wr;
  logic        w_ir_load;
  logic        w_pc_inc;
  logic        w_pc_load;
  logic        w_reg_we;
  logic        w_halted;
  logic        w_trap;

  // IR[11:4] carries operand fields consumed by the datapath, not by control
  logic        w_unused_ir_bits;
  assign w_unused_ir_bits = ^r_ir[11:4];

  ctrl_opdec u_opdec (
    .i_opcode    (r_ir[15:12]),
    .i_func      (r_ir[3:0]),
    .o_op_class  (w_class),
    .o_alu_op    (w_dec_alu_op),
    .o_arith_mux (w_dec_arith_mux)
  );

  // State, instruction register and ALU controls (held until next DECODE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FETCH;
      r_ir        <= 16'h0000;
      r_alu_op    <= 4'b0000;
      r_arith_mux <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_ir_load) begin
        r_ir <= bus.instr_in;
      end
      if (r_state == DECODE) begin
        r_alu_op    <= w_dec_alu_op;
        r_arith_mux <= w_dec_arith_mux;
      end
    end
  end

  // Next-state and per-state control outputs
  always_comb begin
    w_next_state = r_state;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_ir_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_pc_load    = 1'b0;
    w_reg_we     = 1'b0;
    w_halted     = 1'b0;
    w_trap       = 1'b0;
    case (r_state)
      FETCH: begin
        w_mem_rd = 1'b1;
        if (bus.mem_ack) begin
          w_ir_load    = 1'b1;
          w_next_state = DECODE;
        end
      end
      DECODE: begin
        w_pc_inc     = 1'b1;
        w_next_state = EXEC;
      end
      EXEC: begin
        case (w_class)
          CLS_ALU:   w_next_state = WB;
          CLS_LOAD:  w_next_state = MEM;
          CLS_STORE: w_next_state = MEM;
          CLS_BRANCH: begin
            w_pc_load    = bus.flag_z;
            w_next_state = FETCH;
          end
          CLS_HALT:  w_next_state = HALT;
          default: begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
            w_next_state = TRAP;
`else
            w_next_state = FETCH;
`endif
          end
        endcase
      end
      MEM: begin
        // IR still holds the memory instruction, so its class picks the access
        if (w_class == CLS_LOAD) begin
          w_mem_rd = 1'b1;
          if (bus.mem_ack) begin
            w_next_state = WB;
          end
        end else begin
          w_mem_wr = 1'b1;
          if (bus.mem_ack) begin
            w_next_state = FETCH;
          end
        end
      end
      WB: begin
        w_reg_we     = 1'b1;
        w_next_state = FETCH;
      end
      HALT: begin
        w_halted = 1'b1;
      end
      TRAP: begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
        w_halted = 1'b1;
        w_trap   = 1'b1;
`else
        w_next_state = FETCH;
`endif
      end
      default: begin
        w_next_state = FETCH;
      end
    endcase
  end

  // Reset forces every output low at once, dropping any pending request
  assign bus.mem_rd    = w_mem_rd  & ~rst;
  assign bus.mem_wr    = w_mem_wr  & ~rst;
  assign bus.ir_load   = w_ir_load & ~rst;
  assign bus.pc_inc    = w_pc_inc  & ~rst;
  assign bus.pc_load   = w_pc_load & ~rst;
  assign bus.reg_we    = w_reg_we  & ~rst;
  assign bus.halted    = w_halted  & ~rst;
  assign bus.trap      = w_trap    & ~rst;
  assign bus.alu_op    = (r_state == TRAP) ? 4'b0000 : r_alu_op;
  assign bus.arith_mux = (r_state == TRAP) ? 1'b0 : r_arith_mux;

endmodule : ctrl_sequencer
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_sequencer
//  Brief    : Directed self-checking bench for ctrl_sequencer. Inputs change
//             on the falling edge; outputs are checked 1 ns later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  ctrl_sequencer_if bus_if ();

  ctrl_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: rd wr ld inc pcl we mux hlt trp alu_op[3:0]
  function automatic logic [12:0] pk(input logic rd, input logic wr, input logic ld,
                                     input logic inc, input logic pcl, input logic we,
                                     input logic mux, input logic hlt, input logic trp,
                                     input logic [3:0] op);
    return {rd, wr, ld, inc, pcl, we, mux, hlt, trp, op};
  endfunction

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {bus_if.mem_rd, bus_if.mem_wr, bus_if.ir_load, bus_if.pc_inc,
           bus_if.pc_load, bus_if.reg_we, bus_if.arith_mux, bus_if.halted,
           bus_if.trap, bus_if.alu_op};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance one cycle, apply inputs on the falling edge, settle 1 ns
  task automatic d(input logic ack, input logic [15:0] instr, input logic fz);
    @(negedge clk);
    bus_if.mem_ack  = ack;
    bus_if.instr_in = instr;
    bus_if.flag_z   = fz;
    #1;
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus_if.mem_ack = 1'b0;
    #1;
    chk({tag, "_in_rst"}, pk(0,0,0,0,0,0,0,0,0,4'h0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, "_after_rst"}, pk(1,0,0,0,0,0,0,0,0,4'h0));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus_if.mem_ack  = 1'b0;
    bus_if.instr_in = 16'h0000;
    bus_if.flag_z   = 1'b0;
    #1;
    chk("reset_state", pk(0,0,0,0,0,0,0,0,0,4'h0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("fetch_after_rst", pk(1,0,0,0,0,0,0,0,0,4'h0));

    // ALU 16'h0051, zero-wait fetch: FETCH DECODE EXEC WB
    d(1, 16'h0051, 0); chk("alu_fetch",  pk(1,0,1,0,0,0,0,0,0,4'h0));
    d(0, 16'h0000, 0); chk("alu_decode", pk(0,0,0,1,0,0,0,0,0,4'h0));
    d(0, 16'h0000, 0); chk("alu_exec",   pk(0,0,0,0,0,0,0,0,0,4'h1));
    d(0, 16'h0000, 0); chk("alu_wb",     pk(0,0,0,0,0,1,0,0,0,4'h1));
    d(0, 16'h0000, 0); chk("alu_refetch",pk(1,0,0,0,0,0,0,0,0,4'h1));

    // LOAD 16'h9012, ack ignored in DECODE/EXEC, MEM ack on 3rd cycle
    d(1, 16'h9012, 0); chk("ld_fetch",   pk(1,0,1,0,0,0,0,0,0,4'h1));
    d(1, 16'h0000, 0); chk("ld_decode",  pk(0,0,0,1,0,0,0,0,0,4'h1));
    d(1, 16'h0000, 0); chk("ld_exec",    pk(0,0,0,0,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 0); chk("ld_mem1",    pk(1,0,0,0,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 0); chk("ld_mem2",    pk(1,0,0,0,0,0,1,0,0,4'h0));
    d(1, 16'h0000, 0); chk("ld_mem3",    pk(1,0,0,0,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 0); chk("ld_wb",      pk(0,0,0,0,0,1,1,0,0,4'h0));
    d(0, 16'h0000, 0); chk("ld_refetch", pk(1,0,0,0,0,0,1,0,0,4'h0));

    // BRANCH 16'hC000 taken (flag_z=1)
    d(1, 16'hC000, 1); chk("br1_fetch",  pk(1,0,1,0,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 1); chk("br1_decode", pk(0,0,0,1,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 1); chk("br1_exec",   pk(0,0,0,0,1,0,0,0,0,4'h1));
    d(0, 16'h0000, 1); chk("br1_refetch",pk(1,0,0,0,0,0,0,0,0,4'h1));
    // BRANCH not taken (flag_z=0)
    d(1, 16'hC000, 0); chk("br0_fetch",  pk(1,0,1,0,0,0,0,0,0,4'h1));
    d(0, 16'h0000, 0); chk("br0_decode", pk(0,0,0,1,0,0,0,0,0,4'h1));
    d(0, 16'h0000, 0); chk("br0_exec",   pk(0,0,0,0,0,0,0,0,0,4'h1));
    d(0, 16'h0000, 0); chk("br0_refetch",pk(1,0,0,0,0,0,0,0,0,4'h1));

    // STORE 16'hA0B7, zero-wait: FETCH DECODE EXEC MEM
    d(1, 16'hA0B7, 0); chk("st_fetch",   pk(1,0,1,0,0,0,0,0,0,4'h1));
    d(0, 16'h0000, 0); chk("st_decode",  pk(0,0,0,1,0,0,0,0,0,4'h1));
    d(0, 16'h0000, 0); chk("st_exec",    pk(0,0,0,0,0,0,1,0,0,4'h0));
    d(1, 16'h0000, 0); chk("st_mem",     pk(0,1,0,0,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 0); chk("st_refetch", pk(1,0,0,0,0,0,1,0,0,4'h0));

    // HALT 16'hF000: absorbing for 20 cycles with mem_ack toggling
    d(1, 16'hF000, 0); chk("halt_fetch", pk(1,0,1,0,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 0); chk("halt_decode",pk(0,0,0,1,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 0); chk("halt_exec",  pk(0,0,0,0,0,0,0,0,0,4'h0));
    for (int i = 0; i < 20; i++) begin
      d(logic'(i[0]), 16'h0051, 1'b1);
      chk("halt_hold", pk(0,0,0,0,0,0,0,1,0,4'h0));
    end
    rst_pulse("halt_exit");

    // Illegal 16'h3000
    d(1, 16'h3000, 0); chk("ill_fetch",  pk(1,0,1,0,0,0,0,0,0,4'h0));
    d(0, 16'h0000, 0); chk("ill_decode", pk(0,0,0,1,0,0,0,0,0,4'h0));
    d(0, 16'h0000, 0); chk("ill_exec",   pk(0,0,0,0,0,0,0,0,0,4'h0));
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      d(logic'(i[0]), 16'h0051, 0);
      chk("ill_trap_hold", pk(0,0,0,0,0,0,0,1,1,4'h0));
    end
`else
    d(0, 16'h0000, 0); chk("ill_nop_fetch", pk(1,0,0,0,0,0,0,0,0,4'h0));
    d(0, 16'h0000, 0); chk("ill_nop_wait",  pk(1,0,0,0,0,0,0,0,0,4'h0));
`endif
    rst_pulse("ill_exit");

    // STORE 16'hA0B7 with reset asserted while the write waits in MEM
    d(1, 16'hA0B7, 0); chk("st2_fetch",  pk(1,0,1,0,0,0,0,0,0,4'h0));
    d(0, 16'h0000, 0); chk("st2_decode", pk(0,0,0,1,0,0,0,0,0,4'h0));
    d(0, 16'h0000, 0); chk("st2_exec",   pk(0,0,0,0,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 0); chk("st2_mem_wait", pk(0,1,0,0,0,0,1,0,0,4'h0));
    d(0, 16'h0000, 0); chk("st2_mem_wait2",pk(0,1,0,0,0,0,1,0,0,4'h0));
    rst_pulse("st2_mid_mem");
    d(0, 16'h0000, 0); chk("st2_fetch_wait", pk(1,0,0,0,0,0,0,0,0,4'h0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ctrl_sequencer
`default_nettype wire

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr_in  input  16  instruction word from memory; valid when mem_ack=1 during FETCH.
REQ-005 mem_ack  input  1  memory handshake; completes the current mem_rd/mem_wr access.
REQ-006 flag_z  input  1  ALU zero flag; sampled in EXEC for branches.
REQ-007 mem_rd  output  1  memory read request, held until ack.
REQ-008 mem_wr  output  1  memory write request, held until ack.
REQ-009 ir_load  output  1  one-cycle pulse when the internal IR captures instr_in.
REQ-010 pc_inc  output  1  PC increment pulse.
REQ-011 pc_load  output  1  PC load pulse for a taken branch.
REQ-012 reg_we  output  1  register-file write enable.
REQ-013 alu_op  output  4  ALU operation select.
REQ-014 arith_mux  output  1  ALU B-operand select: 1 = immediate, 0 = register.
REQ-015 halted  output  1  high while in HALT.
REQ-016 trap  output  1  illegal-opcode indicator (see Configuration).

Function
REQ-017 The opcode SHALL be IR[15:12]: 0000 ALU, 1001 LOAD, 1010 STORE, 1100 BRANCH, 1111 HALT; all other values are illegal.
REQ-018 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP, encoded as a 3-bit register.
REQ-019 FETCH: mem_rd=1 every cycle until mem_ack=1; in the ack cycle ir_load=1 and IR<=instr_in; next state DECODE.
REQ-020 DECODE: lasts exactly 1 cycle; pc_inc=1; alu_op/arith_mux registered from IR and held until the next DECODE; next state EXEC.
REQ-021 alu_op: IR[3:0] for ALU; 4'b0000 for LOAD/STORE; 4'b0001 for BRANCH; 4'b0000 otherwise. arith_mux is 1 only for LOAD/STORE.
REQ-022 EXEC: lasts 1 cycle. ALU goes to WB. LOAD/STORE go to MEM. BRANCH asserts pc_load=flag_z, then goes to FETCH. HALT goes to HALT. Illegal goes per REQ-030/031.
REQ-023 MEM: LOAD holds mem_rd=1 and STORE holds mem_wr=1 until mem_ack. On ack, LOAD goes to WB and STORE goes to FETCH.
REQ-024 WB: reg_we=1 for exactly 1 cycle; next state FETCH.
REQ-025 HALT: absorbing; halted=1; all request/pulse outputs are 0; only rst exits.
REQ-026 mem_ack outside FETCH/MEM SHALL be ignored; mem_rd and mem_wr are never high together.
REQ-027 Latency: ALU instruction with zero-wait memory = 4 cycles (FETCH..WB); STORE = 4; LOAD = 5; each memory wait cycle adds 1.

Reset
REQ-028 On rst, asynchronously: state=FETCH, IR=16'h0000, every output=0 (including alu_op=4'b0000), regardless of state; mem_rd rises in the first cycle after rst deasserts.
REQ-029 Reset during MEM or FETCH with a request pending SHALL drop the request immediately; no ack is awaited.

Configuration
REQ-030 With CTRL_SEQ_ILLEGAL_TRAP_EN defined: illegal opcode in EXEC goes to TRAP; trap=1 and halted=1 until rst; all other outputs 0.
REQ-031 Without CTRL_SEQ_ILLEGAL_TRAP_EN: illegal opcode is a NOP (EXEC goes to FETCH); trap is tied to 0; TRAP state is unreachable.

Structure
REQ-032 Package ctrl_seq_pkg SHALL hold the state encoding, the opcode constants (4-bit) and the alu_op constants ADD=4'b0000 and SUB=4'b0001.
REQ-033 One combinational sub-module, ctrl_opdec, SHALL map the opcode to its class, alu_op and arith_mux; the FSM and IR remain in ctrl_sequencer.

Verification
REQ-034 ALU: instr 16'h0051, ack immediate -> ir_load at cycle 1, alu_op=4'h1, arith_mux=0, reg_we one cycle in WB, back to FETCH after 4 cycles.
REQ-035 LOAD: instr 16'h9012, MEM ack delayed 3 cycles -> mem_rd held 3 cycles, alu_op=0, arith_mux=1, then reg_we pulse.
REQ-036 BRANCH: 16'hC000 with flag_z=1 -> pc_load pulse in EXEC; with flag_z=0 -> no pc_load; both return to FETCH.
REQ-037 HALT: 16'hF000 -> halted=1 persists for 20 cycles despite mem_ack toggling; rst returns to FETCH.
REQ-038 Illegal: 16'h3000 -> trap=1 latched with the macro; without it, next FETCH follows and trap stays 0.
REQ-039 Reset: assert rst mid-MEM of STORE 16'hA0B7 -> mem_wr drops the same cycle, all outputs 0, state FETCH.
